pipelined_cla_addsub: RTL and testbench

//  Parametrised, pipelined carry-lookahead add/subtract unit for the ALU datapath; next generation of the 32-bit CLA adder.

---
 rtl/addsub_pkg.sv | 26 ++
 rtl/cla_block_n.sv | 60 ++++++
 rtl/pipelined_cla_addsub.sv | 178 +++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// ============================================================================
// Module : addsub_pkg
// Brief  : Opcode encoding and per-stage control payload for the pipelined
//          CLA add/subtract unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Width-independent part of a stage payload; operand and partial-result
   // vectors are sized by WIDTH inside the top module.
   typedef struct packed {
      logic valid;
      op_e  op;
      logic carry;
   } stage_ctl_t;

endpackage

`default_nettype wire

// File: rtl/cla_block_n.sv
// ============================================================================
// Module : cla_block_n
// Brief  : BLOCK_W-bit carry-lookahead block producing sum and group G/P.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_block_n #(
   parameter int BLOCK_W = 8
) (
   input  logic [BLOCK_W-1:0] a,
   input  logic [BLOCK_W-1:0] b,
   input  logic               cin,
   output logic [BLOCK_W-1:0] sum,
   output logic               g,
   output logic               p
);

   logic [BLOCK_W-1:0] w_g;
   logic [BLOCK_W-1:0] w_p;
   logic [BLOCK_W-1:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Each bit carry is a flat sum of products over lower generates and cin.
   always_comb begin
      logic w_pp;
      logic w_cc;
      w_pp   = 1'b1;
      w_cc   = 1'b0;
      w_c    = '0;
      w_c[0] = cin;
      for (int k = 0; k < BLOCK_W - 1; k++) begin
         w_pp = 1'b1;
         w_cc = 1'b0;
         for (int j = k; j >= 0; j--) begin
            w_cc = w_cc | (w_pp & w_g[j]);
            w_pp = w_pp & w_p[j];
         end
         w_c[k+1] = w_cc | (w_pp & cin);
      end
   end

   always_comb begin
      logic w_pp;
      w_pp = 1'b1;
      g    = 1'b0;
      for (int j = BLOCK_W - 1; j >= 0; j--) begin
         g    = g | (w_pp & w_g[j]);
         w_pp = w_pp & w_p[j];
      end
   end

   assign p   = &w_p;
   assign sum = w_p ^ w_c;

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_addsub.sv
// ============================================================================
// Module : pipelined_cla_addsub
// Brief  : Pipelined CLA add/sub with valid/ready handshake and ALU flags.
//          Optional macro SATURATE_EN clamps the result on signed overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_cla_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int BLOCK_W    = 8,
   parameter int NUM_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_overflow,
   output logic             out_lt,
   output logic             out_ne
);

   localparam int c_slice_w = WIDTH / NUM_STAGES;
   localparam int c_nblk    = c_slice_w / BLOCK_W;
   localparam int c_last    = NUM_STAGES - 1;

   logic             w_adv;
   logic [WIDTH-1:0] w_a   [NUM_STAGES];
   logic [WIDTH-1:0] w_b   [NUM_STAGES];
   logic [WIDTH-1:0] w_res [NUM_STAGES];
   stage_ctl_t       w_ctl [NUM_STAGES];

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   logic             r_out_cout;
   logic             r_out_ovf;
   logic             r_out_lt;
   logic             r_out_ne;

   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv;

   // B is inverted once at entry; the SUB carry-in rides in the stage carry.
   assign w_a[0]   = in_a;
   assign w_b[0]   = in_op ? ~in_b : in_b;
   assign w_res[0] = '0;
   assign w_ctl[0] = '{valid: in_valid, op: op_e'(in_op), carry: in_op};

   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      logic [c_slice_w-1:0] w_sum;
      logic [c_nblk-1:0]    w_bg;
      logic [c_nblk-1:0]    w_bp;
      logic [c_nblk:0]      w_bc;
      logic [WIDTH-1:0]     w_res_nxt;

      for (genvar k = 0; k < c_nblk; k++) begin : g_blk
         cla_block_n #(.BLOCK_W(BLOCK_W)) u_blk (
            .a   (w_a[s][s*c_slice_w + k*BLOCK_W +: BLOCK_W]),
            .b   (w_b[s][s*c_slice_w + k*BLOCK_W +: BLOCK_W]),
            .cin (w_bc[k]),
            .sum (w_sum[k*BLOCK_W +: BLOCK_W]),
            .g   (w_bg[k]),
            .p   (w_bp[k])
         );
      end

      always_comb begin
         logic w_pp;
         logic w_cc;
         w_pp    = 1'b1;
         w_cc    = 1'b0;
         w_bc    = '0;
         w_bc[0] = w_ctl[s].carry;
         for (int k = 0; k < c_nblk; k++) begin
            w_pp = 1'b1;
            w_cc = 1'b0;
            for (int j = k; j >= 0; j--) begin
               w_cc = w_cc | (w_pp & w_bg[j]);
               w_pp = w_pp & w_bp[j];
            end
            w_bc[k+1] = w_cc | (w_pp & w_ctl[s].carry);
         end
      end

      always_comb begin
         w_res_nxt = w_res[s];
         w_res_nxt[s*c_slice_w +: c_slice_w] = w_sum;
      end

      if (s < c_last) begin : g_pipe
         logic [WIDTH-1:0] r_a;
         logic [WIDTH-1:0] r_b;
         logic [WIDTH-1:0] r_res;
         stage_ctl_t       r_ctl;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               r_a   <= '0;
               r_b   <= '0;
               r_res <= '0;
               r_ctl <= '0;
            end else if (w_adv) begin
               r_ctl.valid <= w_ctl[s].valid;
               if (w_ctl[s].valid) begin
                  r_a         <= w_a[s];
                  r_b         <= w_b[s];
                  r_res       <= w_res_nxt;
                  r_ctl.op    <= w_ctl[s].op;
                  r_ctl.carry <= w_bc[c_nblk];
               end
            end
         end

         assign w_a[s+1]   = r_a;
         assign w_b[s+1]   = r_b;
         assign w_res[s+1] = r_res;
         assign w_ctl[s+1] = r_ctl;
      end else begin : g_final
         logic             w_ovf;
         logic             w_lt;
         logic             w_ne;
         logic             w_sub;
         logic [WIDTH-1:0] w_out;

         assign w_sub = (w_ctl[s].op == OP_SUB);
         assign w_ovf = (w_a[s][WIDTH-1] == w_b[s][WIDTH-1]) &&
                        (w_res_nxt[WIDTH-1] != w_a[s][WIDTH-1]);
         assign w_lt  = w_sub && (w_res_nxt[WIDTH-1] ^ w_ovf);
         assign w_ne  = w_sub && (|w_res_nxt);
`ifdef SATURATE_EN
         assign w_out = !w_ovf          ? w_res_nxt :
                        w_a[s][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                          {1'b0, {(WIDTH-1){1'b1}}};
`else
         assign w_out = w_res_nxt;
`endif

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               r_out_valid  <= 1'b0;
               r_out_result <= '0;
               r_out_cout   <= 1'b0;
               r_out_ovf    <= 1'b0;
               r_out_lt     <= 1'b0;
               r_out_ne     <= 1'b0;
            end else if (w_adv) begin
               r_out_valid <= w_ctl[s].valid;
               if (w_ctl[s].valid) begin
                  r_out_result <= w_out;
                  r_out_cout   <= w_bc[c_nblk];
                  r_out_ovf    <= w_ovf;
                  r_out_lt     <= w_lt;
                  r_out_ne     <= w_ne;
               end
            end
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_result   = r_out_result;
   assign out_cout     = r_out_cout;
   assign out_overflow = r_out_ovf;
   assign out_lt       = r_out_lt;
   assign out_ne       = r_out_ne;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_addsub.sv
// ============================================================================
// Module : tb_pipelined_cla_addsub
// Brief  : Directed bench for pipelined_cla_addsub (32b/2 stages, 64b/1, 64b/4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipelined_cla_addsub;

`ifdef SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clock;
   logic        reset_n;
   logic        in_valid, in_ready, in_op;
   logic [31:0] in_a, in_b;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic        out_cout, out_overflow, out_lt, out_ne;

   logic        v64, op64, ordy64;
   logic [63:0] a64, b64;
   logic        x1_ir, x1_v, x1_co, x1_ov, x1_lt, x1_ne;
   logic [63:0] x1_r;
   logic        x4_ir, x4_v, x4_co, x4_ov, x4_lt, x4_ne;
   logic [63:0] x4_r;

   int n_total = 0;
   int n_bad   = 0;

   logic [63:0] va [8];
   logic [63:0] vb [8];
   logic        vop[8];

   pipelined_cla_addsub #(.WIDTH(32), .BLOCK_W(8), .NUM_STAGES(2)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_cout(out_cout), .out_overflow(out_overflow), .out_lt(out_lt), .out_ne(out_ne)
   );

   pipelined_cla_addsub #(.WIDTH(64), .BLOCK_W(8), .NUM_STAGES(1)) u_dut_s1 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(v64), .in_ready(x1_ir), .in_a(a64), .in_b(b64), .in_op(op64),
      .out_valid(x1_v), .out_ready(ordy64), .out_result(x1_r),
      .out_cout(x1_co), .out_overflow(x1_ov), .out_lt(x1_lt), .out_ne(x1_ne)
   );

   pipelined_cla_addsub #(.WIDTH(64), .BLOCK_W(8), .NUM_STAGES(4)) u_dut_s4 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(v64), .in_ready(x4_ir), .in_a(a64), .in_b(b64), .in_op(op64),
      .out_valid(x4_v), .out_ready(ordy64), .out_result(x4_r),
      .out_cout(x4_co), .out_overflow(x4_ov), .out_lt(x4_lt), .out_ne(x4_ne)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic on a w-bit slice of 64-bit vectors.
   task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic op,
                        output logic [63:0] r, output logic co, output logic ov,
                        output logic lt, output logic ne);
      logic [64:0] s;
      logic [63:0] m, bp;
      m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      bp = (op ? ~b : b) & m;
      s  = {1'b0, a & m} + {1'b0, bp} + 65'(op);
      r  = s[63:0] & m;
      co = s[w];
      ov = (a[w-1] == bp[w-1]) && (r[w-1] != a[w-1]);
      lt = op && (r[w-1] ^ ov);
      ne = op && (r != 64'd0);
      if (SAT && ov) r = a[w-1] ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
   endtask

   task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] er, input logic eco,
                          input logic eov, input logic elt, input logic ene);
      int cyc;
      @(negedge clock);
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      #1 chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
      end
      chk({tag, "_lat"}, 64'(cyc), 64'd2);
      chk({tag, "_res"}, 64'(out_result), 64'(er));
      chk({tag, "_co"},  64'(out_cout), 64'(eco));
      chk({tag, "_ov"},  64'(out_overflow), 64'(eov));
      chk({tag, "_lt"},  64'(out_lt), 64'(elt));
      chk({tag, "_ne"},  64'(out_ne), 64'(ene));
      @(posedge clock);
   endtask

   initial begin
      logic [63:0] er;
      logic        eco, eov, elt, ene;
      int          idx, k;

      va[0] = 64'h0123_4567_89AB_CDEF; vb[0] = 64'hFEDC_BA98_7654_3210; vop[0] = 1'b0;
      va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'h0000_0000_0000_0001; vop[1] = 1'b0;
      va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h0000_0000_0000_0001; vop[2] = 1'b1;
      va[3] = 64'h0000_0000_DEAD_BEEF; vb[3] = 64'h0000_0000_DEAD_BEEF; vop[3] = 1'b1;
      va[4] = 64'hFFFF_FFFF_0000_FFFF; vb[4] = 64'h0000_0001_0000_0001; vop[4] = 1'b0;
      va[5] = 64'h1234_5678_8000_0000; vb[5] = 64'h0000_0000_8000_0000; vop[5] = 1'b0;
      va[6] = 64'h0000_0000_0000_0005; vb[6] = 64'h0000_0000_0000_0007; vop[6] = 1'b1;
      va[7] = 64'h5555_AAAA_5555_AAAA; vb[7] = 64'hAAAA_5555_AAAA_5556; vop[7] = 1'b0;

      reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b1;
      v64 = 1'b0; a64 = '0; b64 = '0; op64 = 1'b0; ordy64 = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_vld", 64'(out_valid), 64'd0);
      chk("rst_res", 64'(out_result), 64'd0);
      chk("rst_flags", 64'({out_cout, out_overflow, out_lt, out_ne}), 64'd0);
      chk("rst_s1s4", 64'({x1_v, x4_v, x1_r, x4_r}), 64'd0);
      reset_n = 1'b1;

      run_one("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
              SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      run_one("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_one("sub_neg", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);
      run_one("sub_eq", 32'h1234, 32'h1234, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_one("sub_min", 32'h8000_0000, 32'h0000_0001, 1'b1,
              SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
      run_one("add_blk", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
      run_one("add_stg", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h1_0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Streaming with a 3-cycle consumer stall once the pipe is full.
      idx = 0; k = 0;
      for (int cyc = 0; cyc < 60 && k < 8; cyc++) begin
         @(negedge clock);
         out_ready = !(cyc >= 4 && cyc < 7);
         if (idx < 8) begin
            in_valid = 1'b1; in_a = va[idx][31:0]; in_b = vb[idx][31:0]; in_op = vop[idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!out_ready) chk("stall_rdy", 64'(in_ready), 64'd0);
         if (out_valid && out_ready) begin
            model(32, va[k], vb[k], vop[k], er, eco, eov, elt, ene);
            chk($sformatf("strm%0d_res", k), 64'(out_result), er);
            chk($sformatf("strm%0d_flg", k), 64'({out_cout, out_overflow, out_lt, out_ne}),
                64'({eco, eov, elt, ene}));
            k++;
         end
         if (in_valid && in_ready) idx++;
      end
      chk("strm_cnt", 64'(k), 64'd8);
      out_ready = 1'b1;
      in_valid  = 1'b0;

      // Reset with two beats in flight.
      @(negedge clock);
      in_valid = 1'b1; in_a = 32'd100; in_b = 32'd1; in_op = 1'b0;
      @(negedge clock);
      in_a = 32'd200; in_b = 32'd2;
      @(negedge clock);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      chk("rst_fly_vld", 64'(out_valid), 64'd0);
      chk("rst_fly_res", 64'(out_result), 64'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("rst_post_vld", 64'(out_valid), 64'd0);
      end
      run_one("post_rst", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);

      // 64-bit back-to-back stream through 1- and 4-stage builds.
      for (int cyc = 0; cyc < 14; cyc++) begin
         int i1, i4;
         @(negedge clock);
         if (cyc < 8) begin
            v64 = 1'b1; a64 = va[cyc]; b64 = vb[cyc]; op64 = vop[cyc];
         end else begin
            v64 = 1'b0;
         end
         #1;
         i1 = cyc - 1;
         i4 = cyc - 4;
         chk("s1_vld", 64'(x1_v), 64'(i1 >= 0 && i1 < 8));
         chk("s4_vld", 64'(x4_v), 64'(i4 >= 0 && i4 < 8));
         if (i1 >= 0 && i1 < 8) begin
            model(64, va[i1], vb[i1], vop[i1], er, eco, eov, elt, ene);
            chk($sformatf("s1_%0d_res", i1), x1_r, er);
            chk($sformatf("s1_%0d_flg", i1), 64'({x1_co, x1_ov, x1_lt, x1_ne}),
                64'({eco, eov, elt, ene}));
         end
         if (i4 >= 0 && i4 < 8) begin
            model(64, va[i4], vb[i4], vop[i4], er, eco, eov, elt, ene);
            chk($sformatf("s4_%0d_res", i4), x4_r, er);
            chk($sformatf("s4_%0d_flg", i4), 64'({x4_co, x4_ov, x4_lt, x4_ne}),
                64'({eco, eov, elt, ene}));
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
